// File: rtl/keypad_pkg.sv
// Shared types, row drive patterns and column helpers for the 4x4 keypad scanner.
package keypad_pkg;

   typedef enum logic [0:0] {
      IDLE,
      PRESSED
   } kp_state_e;

   typedef enum logic [1:0] {
      NONE,
      SINGLE,
      MULTI
   } scan_kind_e;

   typedef struct packed {
      scan_kind_e kind;
      logic [3:0] code;
   } scan_result_t;

   // Index 0 is the least significant entry, so ROW_PAT[0] = 4'b1110.
   localparam logic [3:0][3:0] ROW_PAT = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
   localparam logic [3:0]      COL_IDLE = 4'b1111;

   localparam scan_result_t RESULT_NONE = '{kind: NONE, code: 4'd0};

   function automatic logic [2:0] count_low(input logic [3:0] col);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 4; i++) begin
         n = n + {2'b00, ~col[i]};
      end
      return n;
   endfunction

   function automatic logic [1:0] first_low(input logic [3:0] col);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!col[i]) begin
            idx = 2'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_row_timer.sv
// Row dwell timer: walks the active-low row drive and flags the last dwell
// cycle of each row (sample_strobe) and of row 3 (scan_done).
module keypad_row_timer
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] keypad_row,
   output logic [1:0] row_idx,
   output logic       sample_strobe,
   output logic       scan_done
);

   localparam int               CNT_W     = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic [1:0]       row_q, row_d;
   logic             strobe;

   always_comb begin
      strobe  = (dwell_q == DWELL_END);
      dwell_d = dwell_q + CNT_W'(1);
      row_d   = row_q;
      if (strobe) begin
         dwell_d = '0;
         row_d   = row_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dwell_q <= '0;
         row_q   <= 2'd0;
      end else begin
         dwell_q <= dwell_d;
         row_q   <= row_d;
      end
   end

   assign keypad_row    = ROW_PAT[row_q];
   assign row_idx       = row_q;
   assign sample_strobe = strobe;
   assign scan_done     = strobe && (row_q == 2'd3);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: classifies each full scan, debounces across scans and
// emits one key event per press. Optional auto-repeat: KEYPAD_REPEAT_EN.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 3,
   parameter int REPEAT_SCANS   = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] keypad_col,
   output logic [3:0] keypad_row,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam logic [3:0] DEB_CNT = 4'(DEBOUNCE_SCANS);

   logic [1:0] row_idx;
   logic       sample_strobe;
   logic       scan_done;

   keypad_row_timer #(
      .SCAN_DIV(SCAN_DIV)
   ) u_row_timer (
      .clk          (clk),
      .rst          (rst),
      .keypad_row   (keypad_row),
      .row_idx      (row_idx),
      .sample_strobe(sample_strobe),
      .scan_done    (scan_done)
   );

   scan_result_t acc_q, acc_d;
   scan_result_t cand_q, cand_d;
   scan_result_t row_res, merged;
   logic [3:0]   stable_q, stable_d;
   kp_state_e    state_q, state_d;
   logic [3:0]   key_code_q, key_code_d;
   logic         key_valid_q, key_valid_d;
   logic         key_held_q, key_held_d;
   logic [2:0]   zeros;
   logic         same;
   logic         settled;

`ifdef KEYPAD_REPEAT_EN
   localparam int              RPT_W    = $clog2(REPEAT_SCANS + 1);
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_SCANS - 1);

   logic [RPT_W-1:0] rpt_q, rpt_d;
`else
   logic repeat_unused;
   assign repeat_unused = (REPEAT_SCANS > 0);
`endif

   // Classify the current row sample and fold it into the running scan result.
   always_comb begin
      zeros   = count_low(keypad_col);
      row_res = RESULT_NONE;
      if (keypad_col == COL_IDLE) begin
         row_res.kind = NONE;
      end else if (zeros == 3'd1) begin
         row_res.kind = SINGLE;
         row_res.code = {row_idx, first_low(keypad_col)};
      end else begin
         row_res.kind = MULTI;
      end

      merged = acc_q;
      if (row_res.kind == SINGLE) begin
         if (acc_q.kind == NONE) begin
            merged = row_res;
         end else begin
            merged.kind = MULTI;
         end
      end else if (row_res.kind == MULTI) begin
         merged.kind = MULTI;
      end
   end

   always_comb begin
      acc_d       = acc_q;
      cand_d      = cand_q;
      stable_d    = stable_q;
      state_d     = state_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      same        = 1'b0;
      settled     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_d       = rpt_q;
`endif

      if (sample_strobe) begin
         acc_d = merged;
      end

      if (scan_done) begin
         acc_d = RESULT_NONE;
         same  = (merged.kind == cand_q.kind) &&
                 ((merged.kind != SINGLE) || (merged.code == cand_q.code));
         if (same) begin
            stable_d = (stable_q == 4'd15) ? stable_q : stable_q + 4'd1;
         end else begin
            cand_d   = merged;
            stable_d = 4'd1;
         end
         settled = (stable_d >= DEB_CNT);

         case (state_q)
            IDLE: begin
               if (settled && (cand_d.kind == SINGLE)) begin
                  key_code_d  = cand_d.code;
                  key_valid_d = 1'b1;
                  key_held_d  = 1'b1;
                  state_d     = PRESSED;
`ifdef KEYPAD_REPEAT_EN
                  rpt_d       = '0;
`endif
               end
            end
            PRESSED: begin
               // Only a debounced clean release leaves PRESSED; other keys are ignored.
               if (settled && (cand_d.kind == NONE)) begin
                  key_held_d = 1'b0;
                  state_d    = IDLE;
               end else begin
`ifdef KEYPAD_REPEAT_EN
                  if ((cand_d.kind == SINGLE) && (cand_d.code == key_code_q)) begin
                     if (rpt_q == RPT_LAST) begin
                        rpt_d       = '0;
                        key_valid_d = 1'b1;
                     end else begin
                        rpt_d = rpt_q + RPT_W'(1);
                     end
                  end else begin
                     rpt_d = '0;
                  end
`endif
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q       <= RESULT_NONE;
         cand_q      <= RESULT_NONE;
         stable_q    <= 4'd0;
         state_q     <= IDLE;
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cand_q      <= cand_d;
         stable_q    <= stable_d;
         state_q     <= state_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

`ifdef KEYPAD_REPEAT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rpt_q <= '0;
      end else begin
         rpt_q <= rpt_d;
      end
   end
`endif

   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a 4-cycle row dwell (16-cycle scan).
module tb_keypad_scanner;

   logic       clk;
   logic       rst;
   logic [3:0] keypad_col;
   logic [3:0] keypad_row;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [15:0] keys;

   int checks;
   int failures;
   int scans;
   int total_pulses;
   int edge_cnt;
   int last_pulse_edge;
   logic [3:0] last_pulse_code;

   keypad_scanner #(
      .SCAN_DIV      (4),
      .DEBOUNCE_SCANS(3),
      .REPEAT_SCANS  (5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .keypad_col(keypad_col),
      .keypad_row(keypad_row),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Passive switch matrix: a pressed key shorts its column to its driven-low row.
   always_comb begin
      keypad_col = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!keypad_row[r] && keys[r*4+c]) begin
               keypad_col[c] = 1'b0;
            end
         end
      end
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) edge_cnt <= 0;
      else      edge_cnt <= edge_cnt + 1;
   end

   initial begin
      total_pulses    = 0;
      last_pulse_edge = -1;
      last_pulse_code = 4'd0;
   end

   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         total_pulses    <= total_pulses + 1;
         last_pulse_edge <= edge_cnt;
         last_pulse_code <= key_code;
      end
   end

   task automatic run_scans(input int n);
      repeat (16 * n) @(negedge clk);
      scans = scans + n;
      #1;
   endtask

   task automatic test_reset;
      logic [3:0] exp_row;
      keys = 16'h0000;
      rst  = 1'b1;
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (keypad_row !== 4'b1110) begin
         failures++; $display("FAIL reset_row: got %b expected 1110", keypad_row);
      end
      checks++;
      if (key_code !== 4'd0) begin
         failures++; $display("FAIL reset_code: got %0d expected 0", key_code);
      end
      checks++;
      if (key_valid !== 1'b0) begin
         failures++; $display("FAIL reset_valid: got %b expected 0", key_valid);
      end
      checks++;
      if (key_held !== 1'b0) begin
         failures++; $display("FAIL reset_held: got %b expected 0", key_held);
      end
      rst = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 3 || k % 4 == 0) begin
            case (k)
               3:       exp_row = 4'b1110;
               4:       exp_row = 4'b1101;
               8:       exp_row = 4'b1011;
               12:      exp_row = 4'b0111;
               default: exp_row = 4'b1110;
            endcase
            checks++;
            if (keypad_row !== exp_row) begin
               failures++;
               $display("FAIL row_seq cycle %0d: got %b expected %b", k, keypad_row, exp_row);
            end
         end
      end
      #1;
      scans = 1;
      $display("reset: row sequence walked, scans=%0d", scans);
   endtask

   task automatic test_single_press;
      int base;
      base = total_pulses;
      keys = 16'h0000;
      keys[9] = 1'b1;
      run_scans(2);
      checks++;
      if (total_pulses - base !== 0) begin
         failures++; $display("FAIL single_early: got %0d pulses expected 0", total_pulses - base);
      end
      run_scans(1);
      checks++;
      if (total_pulses - base !== 1) begin
         failures++; $display("FAIL single_count: got %0d pulses expected 1", total_pulses - base);
      end
      checks++;
      if (last_pulse_code !== 4'd9) begin
         failures++; $display("FAIL single_code: got %0d expected 9", last_pulse_code);
      end
      checks++;
      if (last_pulse_edge !== 16 * scans) begin
         failures++; $display("FAIL single_latency: got edge %0d expected %0d", last_pulse_edge, 16 * scans);
      end
      run_scans(3);
      checks++;
      if (total_pulses - base !== 1 || key_held !== 1'b1) begin
         failures++;
         $display("FAIL single_hold: got pulses=%0d held=%b expected 1/1", total_pulses - base, key_held);
      end
      keys = 16'h0000;
      run_scans(2);
      checks++;
      if (key_held !== 1'b1) begin
         failures++; $display("FAIL single_release_early: got held=%b expected 1", key_held);
      end
      run_scans(1);
      checks++;
      if (key_held !== 1'b0) begin
         failures++; $display("FAIL single_release: got held=%b expected 0", key_held);
      end
      checks++;
      if (key_code !== 4'd9) begin
         failures++; $display("FAIL single_code_kept: got %0d expected 9", key_code);
      end
      $display("single_press: key 9 pulses=%0d", total_pulses - base);
   endtask

   task automatic test_bounce;
      int base;
      base = total_pulses;
      for (int i = 0; i < 10; i++) begin
         keys = 16'h0000;
         keys[9] = (i % 2 == 0);
         run_scans(1);
      end
      checks++;
      if (total_pulses - base !== 0) begin
         failures++; $display("FAIL bounce_quiet: got %0d pulses expected 0", total_pulses - base);
      end
      keys = 16'h0000;
      keys[9] = 1'b1;
      run_scans(2);
      checks++;
      if (total_pulses - base !== 0) begin
         failures++; $display("FAIL bounce_early: got %0d pulses expected 0", total_pulses - base);
      end
      run_scans(1);
      checks++;
      if (total_pulses - base !== 1 || last_pulse_code !== 4'd9 || last_pulse_edge !== 16 * scans) begin
         failures++;
         $display("FAIL bounce_accept: got pulses=%0d code=%0d edge=%0d expected 1/9/%0d",
                  total_pulses - base, last_pulse_code, last_pulse_edge, 16 * scans);
      end
      keys = 16'h0000;
      run_scans(4);
      checks++;
      if (key_held !== 1'b0) begin
         failures++; $display("FAIL bounce_release: got held=%b expected 0", key_held);
      end
      $display("bounce: pulses=%0d", total_pulses - base);
   endtask

   task automatic test_ghost;
      int base;
      base = total_pulses;
      keys = 16'h0000;
      keys[0] = 1'b1;
      keys[5] = 1'b1;
      run_scans(10);
      checks++;
      if (total_pulses - base !== 0 || key_held !== 1'b0) begin
         failures++;
         $display("FAIL ghost_quiet: got pulses=%0d held=%b expected 0/0", total_pulses - base, key_held);
      end
      keys = 16'h0000;
      keys[0] = 1'b1;
      keys[1] = 1'b1;
      run_scans(5);
      checks++;
      if (total_pulses - base !== 0) begin
         failures++; $display("FAIL row_multi_quiet: got %0d pulses expected 0", total_pulses - base);
      end
      keys = 16'h0000;
      keys[0] = 1'b1;
      run_scans(2);
      checks++;
      if (total_pulses - base !== 0) begin
         failures++; $display("FAIL ghost_early: got %0d pulses expected 0", total_pulses - base);
      end
      run_scans(1);
      checks++;
      if (total_pulses - base !== 1 || last_pulse_code !== 4'd0 || key_code !== 4'd0) begin
         failures++;
         $display("FAIL ghost_accept: got pulses=%0d code=%0d expected 1/0", total_pulses - base, last_pulse_code);
      end
      keys = 16'h0000;
      run_scans(4);
      $display("ghost: key 0 accepted after ghost, pulses=%0d", total_pulses - base);
   endtask

   task automatic test_held_second_key;
      int base;
      base = total_pulses;
      keys = 16'h0000;
      keys[3] = 1'b1;
      run_scans(3);
      checks++;
      if (total_pulses - base !== 1 || last_pulse_code !== 4'd3) begin
         failures++;
         $display("FAIL held3_accept: got pulses=%0d code=%0d expected 1/3", total_pulses - base, last_pulse_code);
      end
      keys[12] = 1'b1;
      run_scans(5);
      checks++;
      if (total_pulses - base !== 1 || key_held !== 1'b1 || key_code !== 4'd3) begin
         failures++;
         $display("FAIL second_key_ignored: got pulses=%0d held=%b code=%0d expected 1/1/3",
                  total_pulses - base, key_held, key_code);
      end
      keys = 16'h0000;
      run_scans(2);
      checks++;
      if (key_held !== 1'b1) begin
         failures++; $display("FAIL both_release_early: got held=%b expected 1", key_held);
      end
      run_scans(1);
      checks++;
      if (key_held !== 1'b0) begin
         failures++; $display("FAIL both_release: got held=%b expected 0", key_held);
      end
      keys[12] = 1'b1;
      run_scans(3);
      checks++;
      if (total_pulses - base !== 2 || last_pulse_code !== 4'd12 || last_pulse_edge !== 16 * scans) begin
         failures++;
         $display("FAIL key12_accept: got pulses=%0d code=%0d edge=%0d expected 2/12/%0d",
                  total_pulses - base, last_pulse_code, last_pulse_edge, 16 * scans);
      end
      keys = 16'h0000;
      run_scans(4);
      $display("held_second_key: pulses=%0d last code=%0d", total_pulses - base, last_pulse_code);
   endtask

   task automatic test_repeat;
      int base;
      int exp_new;
      keys = 16'h0000;
      keys[7] = 1'b1;
      base = total_pulses;
      run_scans(3);
      checks++;
      if (total_pulses - base !== 1 || last_pulse_code !== 4'd7) begin
         failures++;
         $display("FAIL key7_accept: got pulses=%0d code=%0d expected 1/7", total_pulses - base, last_pulse_code);
      end
      base = total_pulses;
      for (int k = 1; k <= 20; k++) begin
         run_scans(1);
`ifdef KEYPAD_REPEAT_EN
         exp_new = k / 5;
`else
         exp_new = 0;
`endif
         checks++;
         if (total_pulses - base !== exp_new) begin
            failures++;
            $display("FAIL repeat_count scan %0d: got %0d pulses expected %0d", k, total_pulses - base, exp_new);
         end
      end
      checks++;
      if (last_pulse_code !== 4'd7 || key_held !== 1'b1) begin
         failures++;
         $display("FAIL repeat_code: got code=%0d held=%b expected 7/1", last_pulse_code, key_held);
      end
`ifdef KEYPAD_REPEAT_EN
      checks++;
      if (last_pulse_edge !== 16 * scans) begin
         failures++; $display("FAIL repeat_edge: got %0d expected %0d", last_pulse_edge, 16 * scans);
      end
`endif
      keys = 16'h0000;
      run_scans(4);
      $display("repeat: extra pulses over 20 held scans=%0d", total_pulses - base);
   endtask

   task automatic test_reset_mid_scan;
      int base;
      keys = 16'h0000;
      keys[9] = 1'b1;
      run_scans(2);
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (keypad_row !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
         failures++;
         $display("FAIL midscan_reset: got row=%b code=%0d valid=%b held=%b expected 1110/0/0/0",
                  keypad_row, key_code, key_valid, key_held);
      end
      @(negedge clk);
      rst   = 1'b1;
      scans = 0;
      base  = total_pulses;
      run_scans(2);
      checks++;
      if (total_pulses - base !== 0) begin
         failures++; $display("FAIL midscan_early: got %0d pulses expected 0", total_pulses - base);
      end
      run_scans(1);
      checks++;
      if (total_pulses - base !== 1 || last_pulse_code !== 4'd9 || last_pulse_edge !== 48) begin
         failures++;
         $display("FAIL midscan_accept: got pulses=%0d code=%0d edge=%0d expected 1/9/48",
                  total_pulses - base, last_pulse_code, last_pulse_edge);
      end
      keys = 16'h0000;
      run_scans(4);
      $display("reset_mid_scan: fresh acceptance at edge %0d", last_pulse_edge);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      scans    = 0;
      keys     = 16'h0000;
      rst      = 1'b1;
      test_reset();
      test_single_press();
      test_bounce();
      test_ghost();
      test_held_second_key();
      test_repeat();
      test_reset_mid_scan();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
